// File: rtl/mips_cpu_control_fsm.sv
// Multi-cycle sequencing controller for the MIPS CPU.
// Decides when the bus is strobed, when the IR/PC/register file are written,
// implements the branch delay slot and interlocks HI/LO against the
// mult/div unit. Field-level datapath selects stay with the decoder.
//
// Bus handshake: a request (mem_read or mem_write) is held steady for as long
// as waitrequest=1; the transfer completes in the first cycle the request is
// high and waitrequest=0, and every side effect of that transfer (ir_write,
// reg_write, pc_write) is asserted in that same cycle only.
module mips_cpu_control_fsm #(
    parameter int MULT_CYCLES     = 2,
    parameter int DIV_CYCLES      = 32,
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        waitrequest,
    input  logic        alu_cond,
    input  logic        target_zero,
    output logic        active,
    output logic        fault,
    output logic        mem_read,
    output logic        mem_write,
    output logic        addr_sel,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_src,
    output logic        target_write,
    output logic        reg_write,
    output logic        spc_reg_write,
    output logic        muldiv_start,
    output logic        muldiv_busy,
    // Current state: 0 = FETCH, 1 = EXEC, 2 = MEM, 3 = HALTED
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_EXEC   = 2'd1,
        S_MEM    = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    localparam logic [5:0] L_MULT_CNT = 6'(MULT_CYCLES);
    localparam logic [5:0] L_DIV_CNT  = 6'(DIV_CYCLES);

    state_t     r_state;
    state_t     w_state_next;
    logic       r_pending;        // a taken branch/jump target waits for the delay slot
    logic       r_halt_pending;   // halt once the delay slot completes
    logic       r_fault;
    logic [5:0] r_busy_cnt;

    logic       w_pending_next;
    logic       w_halt_pending_next;
    logic       w_fault_next;

    logic [5:0] w_opcode;
    logic [5:0] w_funct;
    logic [4:0] w_rt;
    logic       w_unused_instr_bits;

    logic       w_is_alu;
    logic       w_is_load;
    logic       w_is_store;
    logic       w_is_branch;
    logic       w_is_jump;
    logic       w_is_link;
    logic       w_is_muldiv;
    logic       w_is_mul;
    logic       w_is_mfhilo;
    logic       w_is_mthilo;
    logic       w_is_illegal;

    logic       w_busy;
    logic       w_in_exec;
    logic       w_ds_fault;
    logic       w_exec_stall;
    logic       w_illegal_halt;
    logic       w_exec_done;
    logic       w_mem_done;
    logic       w_complete;
    logic       w_set_pending;
    logic       w_set_halt;
    logic       w_start;

    assign w_opcode            = instr[31:26];
    assign w_rt                = instr[20:16];
    assign w_funct             = instr[5:0];
    assign w_unused_instr_bits = ^{instr[25:21], instr[15:6]};

    // Classify the instruction register into the sequencing classes
    always_comb begin
        w_is_alu     = 1'b0;
        w_is_load    = 1'b0;
        w_is_store   = 1'b0;
        w_is_branch  = 1'b0;
        w_is_jump    = 1'b0;
        w_is_link    = 1'b0;
        w_is_muldiv  = 1'b0;
        w_is_mul     = 1'b0;
        w_is_mfhilo  = 1'b0;
        w_is_mthilo  = 1'b0;
        w_is_illegal = 1'b0;
        case (w_opcode)
            6'h00: begin
                case (w_funct)
                    6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                    6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                    6'h26, 6'h27, 6'h2A, 6'h2B: w_is_alu = 1'b1;
                    6'h08: w_is_jump = 1'b1;
                    6'h09: begin
                        w_is_jump = 1'b1;
                        w_is_link = 1'b1;
                    end
                    6'h10, 6'h12: w_is_mfhilo = 1'b1;
                    6'h11, 6'h13: w_is_mthilo = 1'b1;
                    6'h18, 6'h19: begin
                        w_is_muldiv = 1'b1;
                        w_is_mul    = 1'b1;
                    end
                    6'h1A, 6'h1B: w_is_muldiv = 1'b1;
                    default: w_is_illegal = 1'b1;
                endcase
            end
            6'h01: begin
                case (w_rt)
                    5'h00, 5'h01: w_is_branch = 1'b1;
                    5'h10, 5'h11: begin
                        w_is_branch = 1'b1;
                        w_is_link   = 1'b1;
                    end
                    default: w_is_illegal = 1'b1;
                endcase
            end
            6'h02: w_is_jump = 1'b1;
            6'h03: begin
                w_is_jump = 1'b1;
                w_is_link = 1'b1;
            end
            6'h04, 6'h05, 6'h06, 6'h07: w_is_branch = 1'b1;
            6'h08, 6'h09, 6'h0A, 6'h0B,
            6'h0C, 6'h0D, 6'h0E, 6'h0F: w_is_alu = 1'b1;
            6'h20, 6'h21, 6'h22, 6'h23,
            6'h24, 6'h25, 6'h26: w_is_load = 1'b1;
            6'h28, 6'h29, 6'h2A, 6'h2B, 6'h2E: w_is_store = 1'b1;
            default: w_is_illegal = 1'b1;
        endcase
    end

    assign w_busy         = (r_busy_cnt != 6'd0);
    assign w_in_exec      = (r_state == S_EXEC);
    // Any control transfer inside a delay slot is architecturally undefined: stop.
    assign w_ds_fault     = w_in_exec && (w_is_branch || w_is_jump) && r_pending;
    assign w_exec_stall   = w_in_exec && (w_is_muldiv || w_is_mfhilo || w_is_mthilo) && w_busy;
    assign w_illegal_halt = w_in_exec && w_is_illegal && HALT_ON_ILLEGAL;
    assign w_exec_done    = w_in_exec && !w_is_load && !w_is_store && !w_ds_fault
                            && !w_exec_stall && !w_illegal_halt;
    assign w_mem_done     = (r_state == S_MEM) && !waitrequest;
    assign w_complete     = w_exec_done || w_mem_done;
    assign w_set_pending  = w_exec_done && ((w_is_branch && alu_cond) || w_is_jump);
    assign w_set_halt     = w_exec_done && w_is_jump && target_zero;
    assign w_start        = rst_n && w_exec_done && w_is_muldiv;

    // State, delay-slot/halt flags, fault flag and mult/div busy counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= S_FETCH;
            r_pending      <= 1'b0;
            r_halt_pending <= 1'b0;
            r_fault        <= 1'b0;
            r_busy_cnt     <= 6'd0;
        end else begin
            r_state        <= w_state_next;
            r_pending      <= w_pending_next;
            r_halt_pending <= w_halt_pending_next;
            r_fault        <= w_fault_next;
            if (w_start) begin
                r_busy_cnt <= w_is_mul ? L_MULT_CNT : L_DIV_CNT;
            end else if (w_busy) begin
                r_busy_cnt <= r_busy_cnt - 6'd1;
            end
        end
    end

    // Next state and next flag values
    always_comb begin
        w_state_next        = r_state;
        w_pending_next      = r_pending;
        w_halt_pending_next = r_halt_pending;
        w_fault_next        = r_fault;
        case (r_state)
            S_FETCH: begin
                if (!waitrequest) begin
                    w_state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                if (w_ds_fault || w_illegal_halt) begin
                    w_state_next = S_HALTED;
                    w_fault_next = 1'b1;
                end else if (w_is_load || w_is_store) begin
                    w_state_next = S_MEM;
                end
            end
            S_MEM:    w_state_next = r_state;
            S_HALTED: w_state_next = S_HALTED;
            default:  w_state_next = S_FETCH;
        endcase
        // Completion: the delay-slot flag is replaced by this instruction's own,
        // and a halt requested by an earlier jump takes effect now.
        if (w_complete) begin
            w_pending_next = w_set_pending;
            if (r_halt_pending) begin
                w_halt_pending_next = 1'b0;
                w_state_next        = S_HALTED;
            end else begin
                w_halt_pending_next = w_set_halt;
                w_state_next        = S_FETCH;
            end
        end
    end

    // Strobes, all combinational and forced low while reset is held
    always_comb begin
        active        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        addr_sel      = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_src        = 1'b0;
        target_write  = 1'b0;
        reg_write     = 1'b0;
        spc_reg_write = 1'b0;
        muldiv_start  = 1'b0;
        if (rst_n) begin
            active = (r_state != S_HALTED);
            case (r_state)
                S_FETCH: begin
                    mem_read = 1'b1;
                    ir_write = !waitrequest;
                end
                S_EXEC: begin
                    if (w_exec_done) begin
                        pc_write      = 1'b1;
                        pc_src        = r_pending;
                        target_write  = w_set_pending;
                        reg_write     = w_is_alu || w_is_link || w_is_mfhilo;
                        spc_reg_write = w_is_mthilo;
                        muldiv_start  = w_is_muldiv;
                    end
                end
                S_MEM: begin
                    addr_sel  = 1'b1;
                    mem_read  = w_is_load;
                    mem_write = w_is_store;
                    if (w_mem_done) begin
                        pc_write  = 1'b1;
                        pc_src    = r_pending;
                        reg_write = w_is_load;
                    end
                end
                default: active = 1'b0;
            endcase
        end
    end

    assign fault       = r_fault;
    assign muldiv_busy = w_busy;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_mips_cpu_control_fsm.sv
// Bench for mips_cpu_control_fsm: a cycle-by-cycle vector table followed by
// hand-written sequences for the multi-cycle corner cases.
module tb_mips_cpu_control_fsm;

    localparam logic [1:0] ST_F = 2'd0;
    localparam logic [1:0] ST_E = 2'd1;
    localparam logic [1:0] ST_M = 2'd2;
    localparam logic [1:0] ST_H = 2'd3;

    // Output bit positions in the packed observation vector
    localparam logic [12:0] B_ACT = 13'h1000;
    localparam logic [12:0] B_FLT = 13'h0800;
    localparam logic [12:0] B_MR  = 13'h0400;
    localparam logic [12:0] B_MW  = 13'h0200;
    localparam logic [12:0] B_AS  = 13'h0100;
    localparam logic [12:0] B_IW  = 13'h0080;
    localparam logic [12:0] B_PW  = 13'h0040;
    localparam logic [12:0] B_PS  = 13'h0020;
    localparam logic [12:0] B_TW  = 13'h0010;
    localparam logic [12:0] B_RW  = 13'h0008;
    localparam logic [12:0] B_SW  = 13'h0004;
    localparam logic [12:0] B_MS  = 13'h0002;
    localparam logic [12:0] B_MB  = 13'h0001;
    localparam logic [12:0] B_NONE = 13'h0000;

    localparam logic [31:0] I_NOP    = 32'h0000_0000;
    localparam logic [31:0] I_ADDU   = 32'h0022_1821;
    localparam logic [31:0] I_ORI    = 32'h3422_0001;
    localparam logic [31:0] I_LW     = 32'h8C22_0000;
    localparam logic [31:0] I_SW     = 32'hAC22_0000;
    localparam logic [31:0] I_BEQ    = 32'h1022_0004;
    localparam logic [31:0] I_BGEZAL = 32'h0431_0004;
    localparam logic [31:0] I_J      = 32'h0800_0010;
    localparam logic [31:0] I_JAL    = 32'h0C00_0010;
    localparam logic [31:0] I_JR     = 32'h03E0_0008;
    localparam logic [31:0] I_MULT   = 32'h0022_0018;
    localparam logic [31:0] I_DIVU   = 32'h0022_001B;
    localparam logic [31:0] I_MFLO   = 32'h0000_1812;
    localparam logic [31:0] I_MTHI   = 32'h0020_0011;
    localparam logic [31:0] I_ILL    = 32'hFC00_0000;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic        waitrequest;
    logic        alu_cond;
    logic        target_zero;
    logic        active;
    logic        fault;
    logic        mem_read;
    logic        mem_write;
    logic        addr_sel;
    logic        ir_write;
    logic        pc_write;
    logic        pc_src;
    logic        target_write;
    logic        reg_write;
    logic        spc_reg_write;
    logic        muldiv_start;
    logic        muldiv_busy;
    logic [1:0]  dbg_state;
    logic [12:0] w_outs;

    int n_checks;
    int n_errors;

    typedef struct {
        logic        r;
        logic [31:0] ins;
        logic        wr;
        logic        c;
        logic        t;
        logic [1:0]  st;
        logic [12:0] eb;
    } vec_t;

    vec_t vq[$];

    mips_cpu_control_fsm dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .instr         (instr),
        .waitrequest   (waitrequest),
        .alu_cond      (alu_cond),
        .target_zero   (target_zero),
        .active        (active),
        .fault         (fault),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .addr_sel      (addr_sel),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .pc_src        (pc_src),
        .target_write  (target_write),
        .reg_write     (reg_write),
        .spc_reg_write (spc_reg_write),
        .muldiv_start  (muldiv_start),
        .muldiv_busy   (muldiv_busy),
        .dbg_state     (dbg_state)
    );

    assign w_outs = {active, fault, mem_read, mem_write, addr_sel, ir_write, pc_write,
                     pc_src, target_write, reg_write, spc_reg_write, muldiv_start, muldiv_busy};

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected finish earlier");
        $fatal(1, "watchdog");
    end

    task automatic add(input logic r, input logic [31:0] ins, input logic wr,
                       input logic c, input logic t, input logic [1:0] st,
                       input logic [12:0] eb);
        vec_t v;
        v.r = r; v.ins = ins; v.wr = wr; v.c = c; v.t = t; v.st = st; v.eb = eb;
        vq.push_back(v);
    endtask

    // Drive one cycle's inputs just after the falling edge, then settle.
    task automatic step(input logic r, input logic [31:0] ins, input logic wr,
                        input logic c, input logic t);
        @(negedge clk);
        rst_n       = r;
        instr       = ins;
        waitrequest = wr;
        alu_cond    = c;
        target_zero = t;
        #1;
    endtask

    task automatic check(input string name, input logic [1:0] est, input logic [12:0] eb);
        n_checks++;
        if (dbg_state !== est || w_outs !== eb) begin
            n_errors++;
            $display("FAIL %s: got state=%0d outs=%013b, expected state=%0d outs=%013b",
                     name, dbg_state, w_outs, est, eb);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n       = 1'b0;
        instr       = I_NOP;
        waitrequest = 1'b0;
        alu_cond    = 1'b0;
        target_zero = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        int e;
        int rw_e;
        int busy_n;
        n_checks    = 0;
        n_errors    = 0;
        rst_n       = 1'b0;
        instr       = I_NOP;
        waitrequest = 1'b0;
        alu_cond    = 1'b0;
        target_zero = 1'b0;
        repeat (2) @(posedge clk);

        // Cycle-by-cycle table: rst_n, instr, waitrequest, alu_cond, target_zero, state, outputs
        add(0, I_NOP,    0, 0, 0, ST_F, B_NONE);
        add(1, I_ADDU,   0, 0, 0, ST_F, B_ACT | B_MR | B_IW);
        add(1, I_ADDU,   0, 0, 0, ST_E, B_ACT | B_RW | B_PW);
        add(1, I_LW,     0, 0, 0, ST_F, B_ACT | B_MR | B_IW);
        add(1, I_LW,     0, 0, 0, ST_E, B_ACT);
        add(1, I_LW,     1, 0, 0, ST_M, B_ACT | B_MR | B_AS);
        add(1, I_LW,     1, 0, 0, ST_M, B_ACT | B_MR | B_AS);
        add(1, I_LW,     1, 0, 0, ST_M, B_ACT | B_MR | B_AS);
        add(1, I_LW,     0, 0, 0, ST_M, B_ACT | B_MR | B_AS | B_RW | B_PW);
        add(1, I_SW,     0, 0, 0, ST_F, B_ACT | B_MR | B_IW);
        add(1, I_SW,     0, 0, 0, ST_E, B_ACT);
        add(1, I_SW,     0, 0, 0, ST_M, B_ACT | B_MW | B_AS | B_PW);
        add(1, I_BEQ,    1, 0, 0, ST_F, B_ACT | B_MR);
        add(1, I_BEQ,    0, 0, 0, ST_F, B_ACT | B_MR | B_IW);
        add(1, I_BEQ,    0, 1, 0, ST_E, B_ACT | B_TW | B_PW);
        add(1, I_ADDU,   0, 0, 0, ST_F, B_ACT | B_MR | B_IW);
        add(1, I_ADDU,   0, 0, 0, ST_E, B_ACT | B_RW | B_PW | B_PS);
        add(1, I_ORI,    0, 0, 0, ST_F, B_ACT | B_MR | B_IW);
        add(1, I_ORI,    0, 0, 0, ST_E, B_ACT | B_RW | B_PW);
        add(1, I_BEQ,    0, 0, 0, ST_F, B_ACT | B_MR | B_IW);
        add(1, I_BEQ,    0, 0, 0, ST_E, B_ACT | B_PW);
        add(1, I_ADDU,   0, 0, 0, ST_F, B_ACT | B_MR | B_IW);
        add(1, I_ADDU,   0, 0, 0, ST_E, B_ACT | B_RW | B_PW);
        add(1, I_BGEZAL, 0, 0, 0, ST_F, B_ACT | B_MR | B_IW);
        add(1, I_BGEZAL, 0, 0, 0, ST_E, B_ACT | B_RW | B_PW);
        add(1, I_JAL,    0, 0, 0, ST_F, B_ACT | B_MR | B_IW);
        add(1, I_JAL,    0, 0, 0, ST_E, B_ACT | B_TW | B_RW | B_PW);
        add(1, I_MULT,   0, 0, 0, ST_F, B_ACT | B_MR | B_IW);
        add(1, I_MULT,   0, 0, 0, ST_E, B_ACT | B_MS | B_PW | B_PS);
        add(1, I_MTHI,   0, 0, 0, ST_F, B_ACT | B_MR | B_IW | B_MB);
        add(1, I_MTHI,   0, 0, 0, ST_E, B_ACT | B_MB);
        add(1, I_MTHI,   0, 0, 0, ST_E, B_ACT | B_SW | B_PW);
        add(1, I_JR,     0, 0, 0, ST_F, B_ACT | B_MR | B_IW);
        add(1, I_JR,     0, 0, 1, ST_E, B_ACT | B_TW | B_PW);
        add(1, I_NOP,    0, 0, 0, ST_F, B_ACT | B_MR | B_IW);
        add(1, I_NOP,    0, 0, 0, ST_E, B_ACT | B_RW | B_PW | B_PS);
        add(1, I_NOP,    0, 0, 0, ST_H, B_NONE);
        add(1, I_ADDU,   0, 0, 0, ST_H, B_NONE);

        for (int i = 0; i < vq.size(); i++) begin
            step(vq[i].r, vq[i].ins, vq[i].wr, vq[i].c, vq[i].t);
            check($sformatf("vec%0d", i), vq[i].st, vq[i].eb);
        end

        // DIVU then MFLO: MFLO must complete exactly 32 edges after the start edge
        do_reset();
        step(1, I_DIVU, 0, 0, 0);
        check("divu_fetch", ST_F, B_ACT | B_MR | B_IW);
        step(1, I_DIVU, 0, 0, 0);
        check("divu_exec", ST_E, B_ACT | B_MS | B_PW);
        e      = -1;
        rw_e   = -1;
        busy_n = 0;
        while (e < 80 && rw_e < 0) begin
            step(1, I_MFLO, 0, 0, 0);
            e++;
            if (muldiv_busy) busy_n++;
            if (reg_write) rw_e = e;
        end
        check_int("mflo_reg_write_edge", rw_e, 32);
        check_int("div_busy_cycles", busy_n, 32);
        check("mflo_done", ST_E, B_ACT | B_RW | B_PW);
        step(1, I_ADDU, 0, 0, 0);
        check("after_mflo_fetch", ST_F, B_ACT | B_MR | B_IW);

        // Reset asserted while a load is stalled in MEM
        do_reset();
        step(1, I_LW, 0, 0, 0);
        check("rmem_fetch", ST_F, B_ACT | B_MR | B_IW);
        step(1, I_LW, 0, 0, 0);
        check("rmem_exec", ST_E, B_ACT);
        step(1, I_LW, 1, 0, 0);
        check("rmem_mem", ST_M, B_ACT | B_MR | B_AS);
        step(0, I_LW, 1, 0, 0);
        step(0, I_LW, 1, 0, 0);
        check("rmem_after_reset", ST_F, B_NONE);
        step(1, I_ADDU, 0, 0, 0);
        check("rmem_release", ST_F, B_ACT | B_MR | B_IW);

        // Reset clears a running busy counter
        do_reset();
        step(1, I_DIVU, 0, 0, 0);
        step(1, I_DIVU, 0, 0, 0);
        check("rbusy_start", ST_E, B_ACT | B_MS | B_PW);
        step(0, I_NOP, 0, 0, 0);
        step(0, I_NOP, 0, 0, 0);
        check("rbusy_cleared", ST_F, B_NONE);

        // Illegal opcode halts with fault
        do_reset();
        step(1, I_ILL, 0, 0, 0);
        check("ill_fetch", ST_F, B_ACT | B_MR | B_IW);
        step(1, I_ILL, 0, 0, 0);
        check("ill_exec", ST_E, B_ACT);
        step(1, I_ILL, 0, 0, 0);
        check("ill_halted", ST_H, B_FLT);
        step(1, I_ADDU, 0, 0, 0);
        check("ill_terminal", ST_H, B_FLT);

        // Branch in the delay slot of a jump
        do_reset();
        step(1, I_J, 0, 0, 0);
        check("ds_j_fetch", ST_F, B_ACT | B_MR | B_IW);
        step(1, I_J, 0, 0, 0);
        check("ds_j_exec", ST_E, B_ACT | B_TW | B_PW);
        step(1, I_BEQ, 0, 0, 0);
        check("ds_beq_fetch", ST_F, B_ACT | B_MR | B_IW);
        step(1, I_BEQ, 0, 1, 0);
        check("ds_beq_exec", ST_E, B_ACT);
        step(1, I_ADDU, 0, 0, 0);
        check("ds_halted", ST_H, B_FLT);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
